// File: rtl/sr04_pkg.sv
// Shared definitions for the SR04 ultrasonic controller and its distance filter.
package sr04_pkg;

  localparam int unsigned DIST_W_DEF = 24;
  localparam int unsigned REJ_CNT_W  = 8;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/sr04_ring_buf.sv
// DEPTH x DIST_W sample store for the moving average. Exposes the slot about to be
// overwritten (read-before-write) and supports filling every slot at once.
module sr04_ring_buf #(
  parameter int unsigned DIST_W = 24,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_fill,
  input  logic [DIST_W-1:0] i_data,
  output logic [DIST_W-1:0] o_old
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DIST_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wp;

  // Oldest sample, i.e. the one the next write replaces.
  assign o_old = r_mem[r_wp];

  // Storage and write pointer; DEPTH is a power of two so the pointer wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp <= '0;
    end else if (i_fill) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= i_data;
      r_wp <= '0;
    end else if (i_we) begin
      r_mem[r_wp] <= i_data;
      r_wp        <= r_wp + PTR_W'(1);
    end
  end

endmodule

// File: rtl/sr04_dist_filter.sv
// Range-qualified moving-average filter for SR04 distance results, with staleness flag.
// Optional feature macro: SR04_FILT_REJECT_EN enables the MIN_DIST/MAX_DIST range check
// and the reject counter; without it every sample is accepted and reject_cnt reads 0.
module sr04_dist_filter
  import sr04_pkg::*;
#(
  parameter int unsigned DIST_W      = DIST_W_DEF,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MIN_DIST    = 2,
  parameter int unsigned MAX_DIST    = 400,
  parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DIST_W-1:0]    in_dist,
  output logic                 out_valid,
  output logic [DIST_W-1:0]    out_dist,
  output logic                 stale,
  output logic [REJ_CNT_W-1:0] reject_cnt
);

  localparam int unsigned LOG2_D = $clog2(DEPTH);
  localparam int unsigned SUM_W  = DIST_W + LOG2_D;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

  if ((MIN_DIST > MAX_DIST) || (DEPTH < 2) || (DEPTH > 16) || ((1 << LOG2_D) != DEPTH))
  begin : g_bad_param
    $error("sr04_dist_filter: bad DEPTH or MIN_DIST/MAX_DIST");
  end

  logic              w_in_ok;
  logic              r_s1_valid;
  logic [DIST_W-1:0] r_s1_dist;
  logic              w_accept;
  logic              w_fill;
  logic              w_we;
  logic [DIST_W-1:0] w_old;
  logic [SUM_W-1:0]  r_sum;
  logic              r_s2_valid;
  logic [TO_W-1:0]   r_to_cnt;
  state_e            r_state;

`ifdef SR04_FILT_REJECT_EN
  logic [REJ_CNT_W-1:0] r_rej_cnt;

  assign w_in_ok = (in_dist >= DIST_W'(MIN_DIST)) && (in_dist <= DIST_W'(MAX_DIST));

  // Count out-of-range strobes, saturating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rej_cnt <= '0;
    end else if (in_valid && !w_in_ok && (r_rej_cnt != '1)) begin
      r_rej_cnt <= r_rej_cnt + REJ_CNT_W'(1);
    end
  end

  assign reject_cnt = r_rej_cnt;
`else
  assign w_in_ok    = 1'b1;
  assign reject_cnt = '0;
`endif

  // Stage 1: register the sample; only accepted samples travel further.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_dist  <= '0;
    end else begin
      r_s1_valid <= in_valid && w_in_ok;
      r_s1_dist  <= in_dist;
    end
  end

  assign w_accept = r_s1_valid;
  assign w_fill   = w_accept && (r_state == S_EMPTY);
  assign w_we     = w_accept && (r_state == S_RUN);

  sr04_ring_buf #(
    .DIST_W(DIST_W),
    .DEPTH (DEPTH)
  ) u_ring_buf (
    .clk   (clk),
    .rst   (rst),
    .i_we  (w_we),
    .i_fill(w_fill),
    .i_data(r_s1_dist),
    .o_old (w_old)
  );

  // Stage 2a: running sum; a fill re-seeds it as if all DEPTH slots held the sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sum      <= '0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid <= w_accept;
      if (w_fill) begin
        r_sum <= SUM_W'(r_s1_dist) << LOG2_D;
      end else if (w_we) begin
        r_sum <= r_sum - SUM_W'(w_old) + SUM_W'(r_s1_dist);
      end
    end
  end

  // Stage 2b: publish the truncated average with its strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_dist  <= '0;
    end else begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) out_dist <= DIST_W'(r_sum >> LOG2_D);
    end
  end

  // FSM, timeout counter and stale flag; an accept in the expiry cycle takes priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_to_cnt <= '0;
      stale    <= 1'b1;
      r_state  <= S_EMPTY;
    end else if (w_accept) begin
      r_to_cnt <= '0;
      stale    <= 1'b0;
      r_state  <= S_RUN;
    end else if (r_to_cnt != TO_W'(TIMEOUT_CYC)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
      if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        stale   <= 1'b1;
        r_state <= S_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_sr04_dist_filter.sv
// Scoreboard bench for sr04_dist_filter: directed scenarios followed by random traffic,
// checked against a window-of-samples reference model.
module tb_sr04_dist_filter;

  localparam int unsigned DIST_W = 24;
  localparam int unsigned DEPTH  = 4;
  localparam int          MIN_D  = 2;
  localparam int          MAX_D  = 400;
  localparam int          TMO    = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DIST_W-1:0] in_dist = '0;
  logic              out_valid;
  logic [DIST_W-1:0] out_dist;
  logic              stale;
  logic [7:0]        reject_cnt;

  always #5 clk = ~clk;

  sr04_dist_filter #(
    .DIST_W     (DIST_W),
    .DEPTH      (DEPTH),
    .MIN_DIST   (MIN_D),
    .MAX_DIST   (MAX_D),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_dist   (in_dist),
    .out_valid (out_valid),
    .out_dist  (out_dist),
    .stale     (stale),
    .reject_cnt(reject_cnt)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     mon_en = 1'b0;
  int     exp_q[$];
  int     win[$];
  longint last_acc = -1;
  longint prev_acc = -1;
  int     exp_rej = 0;
  int     cur_out = 0;

  function automatic bit accepts(int d);
`ifdef SR04_FILT_REJECT_EN
    return (d >= MIN_D) && (d <= MAX_D);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, then update the model for what the clock edge sampled.
  task automatic step(bit v, int d, bit r);
    longint a;
    bit     reinit;
    int     sum;
    rst      = r;
    in_valid = v;
    in_dist  = d[DIST_W-1:0];
    @(posedge clk);
    cyc++;
    if (!r) begin
      exp_q.delete();
      win.delete();
      last_acc = -1;
      prev_acc = -1;
      exp_rej  = 0;
      cur_out  = 0;
    end else if (v) begin
      if (accepts(d)) begin
        a      = cyc + 1;
        reinit = (last_acc < 0) || (a - last_acc > TMO);
        if (reinit) begin
          win.delete();
          repeat (DEPTH) win.push_back(d);
        end else begin
          void'(win.pop_front());
          win.push_back(d);
        end
        sum = 0;
        foreach (win[i]) sum += win[i];
        exp_q.push_back(sum / DEPTH);
        prev_acc = last_acc;
        last_acc = a;
      end else if (exp_rej < 255) begin
        exp_rej++;
      end
    end
    #1;
  endtask

  function automatic int pick_dist();
    case ($urandom_range(0, 9))
      0:       return $urandom_range(0, 1);
      1:       return $urandom_range(401, 2000);
      2:       return int'($urandom & 32'h00FF_FFFF);
      3:       return ($urandom_range(0, 1) != 0) ? MIN_D : MAX_D;
      default: return $urandom_range(MIN_D, MAX_D);
    endcase
  endfunction

  // Monitor: pop on every out_valid, otherwise out_dist must hold.
  always @(negedge clk) begin
    longint ref_t;
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", out_valid, 0);
        end else begin
          cur_out = exp_q.pop_front();
          check("out_dist", out_dist, cur_out);
        end
      end else begin
        check("out_dist_hold", out_dist, cur_out);
      end
      ref_t = (last_acc <= cyc) ? last_acc : prev_acc;
      check("stale", stale, ((ref_t < 0) || (cyc - ref_t >= TMO)) ? 1 : 0);
      check("reject_cnt", reject_cnt, exp_rej);
    end
  end

  initial begin
    step(0, 0, 0);
    mon_en = 1'b1;
    repeat (4) step(0, 0, 0);

    // Directed: first sample, averaging ramp, out-of-range pair, timeout and re-init.
    step(1, 100, 1);
    repeat (4) step(1, 200, 1);
    step(1, 500, 1);
    step(1, 1, 1);
    repeat (TMO + 5) step(0, 0, 1);
    step(1, 50, 1);
    repeat (4) step(0, 0, 1);

    // Reset one edge after a sample: nothing may come out.
    step(1, 300, 1);
    step(0, 0, 0);
    repeat (4) step(0, 0, 1);

    // Range boundaries back to back.
    step(1, 1, 1);
    step(1, 2, 1);
    step(1, 400, 1);
    step(1, 401, 1);
    step(1, 0, 1);
    repeat (3) step(0, 0, 1);

    // Gaps around the timeout threshold, including accept coinciding with expiry.
    for (int g = TMO - 2; g <= TMO + 1; g++) begin
      step(1, $urandom_range(MIN_D, MAX_D), 1);
      repeat (g) step(0, 0, 1);
      step(1, $urandom_range(MIN_D, MAX_D), 1);
      step(1, $urandom_range(MIN_D, MAX_D), 1);
    end

    // Random traffic with occasional resets.
    repeat (3000) begin
      step($urandom_range(0, 1), pick_dist(), ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end

    // Enough out-of-range samples to saturate the reject counter.
    for (int i = 0; i < 300; i++) step(1, 1000 + i, 1);

    repeat (5) step(0, 0, 1);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
